// File: rtl/arb_pkg.sv
// Shared types and helpers for the packet arbiters: FSM state encoding and
// one-hot to binary index conversion.
package arb_pkg;

    typedef enum logic {IDLE, OWN} arb_state_e;

    // Widest one-hot vector onehot2idx accepts; callers zero-extend into it.
    localparam int MAX_PORTS = 64;

    function automatic int onehot2idx(input logic [MAX_PORTS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/wrr_pkt_arbiter_rr_pick.sv
// Combinational masked round-robin pick: lowest masked requester, falling back
// to the lowest requester overall, plus the mask of ports strictly above the winner.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    output logic [N-1:0] grant,
    output logic         any,
    output logic [N-1:0] next_mask
);

    logic [N-1:0] masked;
    logic [N-1:0] sel;

    always_comb begin
        masked    = mask & req;
        sel       = (|masked) ? masked : req;
        grant     = sel & (~sel + N'(1));
        any       = |req;
        // An empty grant yields an empty mask, so no special case is needed.
        next_mask = ~(grant | (grant - N'(1)));
    end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin arbiter that locks the grant for whole packets and lets
// each winner send up to its weight in packets before priority rotates.
module wrr_pkt_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int WEIGHT_W = 4,
    localparam int IDX_W    = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N-1:0]          i_req,
    input  logic [N-1:0]          i_last,
    input  logic [N*WEIGHT_W-1:0] i_weight,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [N-1:0]          o_grant,
    output logic [IDX_W-1:0]      o_grant_idx
);

    arb_state_e          state_q, state_d;
    logic [N-1:0]        grant_q, grant_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [N-1:0]        mask_q, mask_d;

    logic [N-1:0]        pick_req, pick_grant, pick_next_mask;
    logic                pick_any;
    logic [WEIGHT_W-1:0] win_weight, credit_load;
    logic                xfer, pkt_done;

    assign o_grant     = grant_q;
    assign o_grant_idx = idx_q;
    assign o_valid     = (state_q == OWN) && (|(grant_q & i_req));
    assign xfer        = o_valid & i_ready;
    assign pkt_done    = xfer & (|(grant_q & i_last));

    // While owning, the current owner is excluded so a release hands over without a bubble.
    assign pick_req = (state_q == OWN) ? (i_req & ~grant_q) : i_req;

    rr_pick #(.N(N)) u_pick (
        .req       (pick_req),
        .mask      (mask_q),
        .grant     (pick_grant),
        .any       (pick_any),
        .next_mask (pick_next_mask)
    );

    always_comb begin
        win_weight = '0;
        for (int p = 0; p < N; p++) begin
            if (pick_grant[p]) win_weight = i_weight[p*WEIGHT_W +: WEIGHT_W];
        end
        credit_load = (win_weight == '0) ? WEIGHT_W'(1) : win_weight;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        credit_d = credit_q;
        mask_d   = mask_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = OWN;
                    grant_d  = pick_grant;
                    idx_d    = IDX_W'(onehot2idx(MAX_PORTS'(pick_grant)));
                    credit_d = credit_load;
                    mask_d   = pick_next_mask;
                end
            end
            OWN: begin
                if (pkt_done) begin
                    if ((credit_q > WEIGHT_W'(1)) && (|(grant_q & i_req))) begin
                        credit_d = credit_q - WEIGHT_W'(1);
                    end else if (pick_any) begin
                        grant_d  = pick_grant;
                        idx_d    = IDX_W'(onehot2idx(MAX_PORTS'(pick_grant)));
                        credit_d = credit_load;
                        mask_d   = pick_next_mask;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        idx_d    = '0;
                        credit_d = '0;
                        mask_d   = ~(grant_q | (grant_q - N'(1)));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            credit_q <= '0;
            mask_q   <= '1;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            credit_q <= credit_d;
            mask_q   <= mask_d;
        end
    end

endmodule

// File: tb/tb_wrr_pkt_arbiter.sv
// Self-checking bench for wrr_pkt_arbiter: directed scenarios plus randomized
// packet traffic compared against an index-based reference model.
module tb_wrr_pkt_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic [N-1:0]  req, last;
    logic [N*WW-1:0] weight;
    logic          ready;
    logic          valid;
    logic [N-1:0]  grant;
    logic [IW-1:0] gidx;

    always #5 clk = ~clk;

    wrr_pkt_arbiter #(.N(N), .WEIGHT_W(WW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_req       (req),
        .i_last      (last),
        .i_weight    (weight),
        .i_ready     (ready),
        .o_valid     (valid),
        .o_grant     (grant),
        .o_grant_idx (gidx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 when idle), packets left, search start port.
    int m_owner, m_credit, m_start;
    // Traffic generator: beats remaining in each port's current packet.
    int beats_left[N];
    int refill_len[N];
    bit rand_refill;

    function automatic int eff_wt(int p);
        int w;
        w = int'(weight[p*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int pick(logic [N-1:0] r, int start);
        for (int i = start; i < N; i++) if (r[i]) return i;
        for (int i = 0; i < N; i++) if (r[i]) return i;
        return -1;
    endfunction

    task automatic win(logic [N-1:0] r);
        int w;
        w = pick(r, m_start);
        m_owner  = w;
        m_credit = eff_wt(w);
        m_start  = w + 1;
    endtask

    task automatic model_edge();
        logic [N-1:0] r;
        if (!rstn) begin
            m_owner = -1; m_credit = 0; m_start = 0;
        end else if (m_owner < 0) begin
            if (req != '0) win(req);
        end else if (req[m_owner] && ready && last[m_owner]) begin
            if (m_credit > 1) m_credit--;
            else begin
                r = req;
                r[m_owner] = 1'b0;
                m_start = m_owner + 1;
                if (r != '0) win(r);
                else m_owner = -1;
            end
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic apply_inputs();
        for (int p = 0; p < N; p++) begin
            req[p]  = (beats_left[p] > 0);
            last[p] = req[p] ? (beats_left[p] == 1) : 1'($urandom_range(0, 1));
        end
        #1;
    endtask

    task automatic tick();
        int own;
        bit x;
        own = m_owner;
        x   = rstn && (own >= 0) && req[own] && ready;
        model_edge();
        @(posedge clk);
        #1;
        if (x) begin
            beats_left[own]--;
            if (beats_left[own] == 0) begin
                if (rand_refill) begin
                    if ($urandom_range(0, 1) == 1) beats_left[own] = $urandom_range(1, 4);
                end else begin
                    beats_left[own] = refill_len[own];
                end
            end
        end
        if (rand_refill) begin
            for (int p = 0; p < N; p++) begin
                if (p != own && beats_left[p] == 0 && $urandom_range(0, 3) == 0)
                    beats_left[p] = $urandom_range(1, 4);
            end
        end
        apply_inputs();
    endtask

    task automatic do_reset(input logic [N*WW-1:0] w);
        weight = w;
        rstn = 1'b0;
        ready = 1'b1;
        rand_refill = 1'b0;
        for (int p = 0; p < N; p++) begin
            beats_left[p] = 0;
            refill_len[p] = 0;
        end
        apply_inputs();
        tick();
        tick();
        rstn = 1'b1;
        apply_inputs();
    endtask

    task automatic test_reset();
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
        n_checks++;
        if (gidx !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_idx got %0d want 0", gidx); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", valid); end
    endtask

    task automatic test_alternate();
        logic [N-1:0] exp;
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        beats_left[0] = 1; refill_len[0] = 1;
        beats_left[2] = 1; refill_len[2] = 1;
        apply_inputs();
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = (k % 2 == 0) ? 4'b0001 : 4'b0100;
            n_checks++;
            if (grant !== exp) begin n_fail++; $display("[TB] FAIL alt_grant[%0d] got %b want %b", k, grant, exp); end
            n_checks++;
            if (valid !== 1'b1) begin n_fail++; $display("[TB] FAIL alt_valid[%0d] got %b want 1", k, valid); end
        end
    endtask

    task automatic test_multibeat();
        logic [4:0] pat;
        pat = 5'b10101;
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        beats_left[1] = 3;
        beats_left[2] = 1;
        apply_inputs();
        tick();
        for (int k = 0; k < 5; k++) begin
            ready = pat[k];
            apply_inputs();
            n_checks++;
            if (grant !== 4'b0010) begin n_fail++; $display("[TB] FAIL mb_hold[%0d] got %b want 0010", k, grant); end
            n_checks++;
            if (valid !== 1'b1) begin n_fail++; $display("[TB] FAIL mb_valid[%0d] got %b want 1", k, valid); end
            tick();
        end
        n_checks++;
        if (grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL mb_next got %b want 0100", grant); end
        ready = 1'b1;
    endtask

    task automatic test_weighted();
        int seq[8] = '{0, 0, 0, 3, 0, 0, 0, 3};
        do_reset({4'd1, 4'd1, 4'd1, 4'd3});
        beats_left[0] = 1; refill_len[0] = 1;
        beats_left[3] = 1; refill_len[3] = 1;
        apply_inputs();
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (gidx !== IW'(seq[k])) begin n_fail++; $display("[TB] FAIL wrr_idx[%0d] got %0d want %0d", k, gidx, seq[k]); end
        end
    endtask

    task automatic test_zero_weight();
        logic [N-1:0] exp;
        do_reset({4'd1, 4'd0, 4'd1, 4'd1});
        beats_left[2] = 1; refill_len[2] = 1;
        apply_inputs();
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = (k % 2 == 0) ? 4'b0100 : 4'b0000;
            n_checks++;
            if (grant !== exp) begin n_fail++; $display("[TB] FAIL w0_grant[%0d] got %b want %b", k, grant, exp); end
        end
    endtask

    task automatic test_wrap();
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        beats_left[3] = 2;
        apply_inputs();
        tick();
        n_checks++;
        if (gidx !== 2'd3) begin n_fail++; $display("[TB] FAIL wrap_own3 got %0d want 3", gidx); end
        beats_left[0] = 1;
        apply_inputs();
        tick();
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("[TB] FAIL wrap_grant got %b want 0001", grant); end
        n_checks++;
        if (gidx !== 2'd0) begin n_fail++; $display("[TB] FAIL wrap_idx got %0d want 0", gidx); end
    endtask

    task automatic test_reset_midpacket();
        do_reset({4'd1, 4'd1, 4'd1, 4'd1});
        beats_left[2] = 3;
        apply_inputs();
        tick();
        tick();
        n_checks++;
        if (grant !== 4'b0100) begin n_fail++; $display("[TB] FAIL mid_own got %b want 0100", grant); end
        rstn = 1'b0;
        apply_inputs();
        tick();
        n_checks++;
        if (grant !== 4'b0000) begin n_fail++; $display("[TB] FAIL mid_rst_grant got %b want 0000", grant); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_valid got %b want 0", valid); end
        rstn = 1'b1;
        for (int p = 0; p < N; p++) beats_left[p] = 0;
        beats_left[1] = 1;
        beats_left[2] = 1;
        apply_inputs();
        tick();
        n_checks++;
        if (grant !== 4'b0010) begin n_fail++; $display("[TB] FAIL mid_after got %b want 0010", grant); end
        n_checks++;
        if (gidx !== 2'd1) begin n_fail++; $display("[TB] FAIL mid_after_idx got %0d want 1", gidx); end
    endtask

    task automatic test_random();
        logic [N*WW-1:0] w;
        for (int p = 0; p < N; p++) w[p*WW +: WW] = WW'($urandom_range(0, 3));
        do_reset(w);
        rand_refill = 1'b1;
        for (int k = 0; k < 400; k++) begin
            ready = ($urandom_range(0, 3) != 0);
            apply_inputs();
            n_checks++;
            if (valid !== (m_owner >= 0 && req[m_owner])) begin
                n_fail++; $display("[TB] FAIL rnd_valid[%0d] got %b want %b", k, valid, (m_owner >= 0 && req[m_owner]));
            end
            tick();
            n_checks++;
            if (grant !== exp_grant()) begin
                n_fail++; $display("[TB] FAIL rnd_grant[%0d] got %b want %b", k, grant, exp_grant());
            end
            n_checks++;
            if (gidx !== IW'((m_owner < 0) ? 0 : m_owner)) begin
                n_fail++; $display("[TB] FAIL rnd_idx[%0d] got %0d want %0d", k, gidx, (m_owner < 0) ? 0 : m_owner);
            end
        end
        rand_refill = 1'b0;
        ready = 1'b1;
    endtask

    initial begin
        m_owner = -1; m_credit = 0; m_start = 0;
        test_reset();
        test_alternate();
        test_multibeat();
        test_weighted();
        test_zero_weight();
        test_wrap();
        test_reset_midpacket();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
